// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequences reads from the weight/input memory and
// accumulates one neuron dot product. Optional macro: NEURON_RELU_EN.
module neuron_mac_seq #(
    parameter int N_IN   = 4,
    parameter int X_BASE = 0,
    parameter int W_BASE = 128,
    parameter int ACC_W  = 20,
    parameter logic signed [ACC_W-1:0] BIAS = '0,
    parameter int SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    output logic [7:0]              abus_r,
    input  logic [7:0]              dbus_r,
    output logic                    busy,
    output logic                    ack,
    output logic signed [7:0]       y,
    output logic signed [ACC_W-1:0] acc
);

    typedef enum logic [1:0] {IDLE, RDX, RDW, ACT} state_t;

    localparam logic [7:0] XB   = 8'(X_BASE);
    localparam logic [7:0] WB   = 8'(W_BASE);
    localparam logic [7:0] LAST = 8'(N_IN - 1);

    state_t                  state_q, state_d;
    logic [7:0]              abus_q, abus_d;
    logic signed [7:0]       x_q, x_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              i_q, i_d;
    logic                    busy_q, busy_d;
    logic                    ack_q, ack_d;
    logic signed [7:0]       y_q, y_d;

    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] t;
    logic signed [7:0]       s;
    logic signed [7:0]       act;

    assign prod     = 16'($signed(x_q)) * 16'($signed(dbus_r));
    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    assign t        = acc_q >>> SHIFT;

    // Saturate the shifted accumulator to 8 bits, then apply activation
    always_comb begin
        s = t[7:0];
        if (!t[ACC_W-1] && (|t[ACC_W-2:7])) begin
            s = 8'sh7f;
        end else if (t[ACC_W-1] && !(&t[ACC_W-2:7])) begin
            s = 8'sh80;
        end
`ifdef NEURON_RELU_EN
        act = s[7] ? 8'sh00 : s;
`else
        act = s;
`endif
    end

    // Next-state and datapath updates for the read/accumulate sequence
    always_comb begin
        state_d = state_q;
        abus_d  = abus_q;
        x_d     = x_q;
        acc_d   = acc_q;
        i_d     = i_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    abus_d  = XB;
                    acc_d   = BIAS;
                    i_d     = 8'd0;
                    busy_d  = 1'b1;
                    state_d = RDX;
                end
            end
            RDX: begin
                x_d     = dbus_r;
                abus_d  = WB + i_q;
                state_d = RDW;
            end
            RDW: begin
                acc_d = acc_q + prod_ext;
                if (i_q == LAST) begin
                    state_d = ACT;
                end else begin
                    i_d     = i_q + 8'd1;
                    abus_d  = XB + i_q + 8'd1;
                    state_d = RDX;
                end
            end
            ACT: begin
                y_d     = act;
                ack_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            abus_q  <= 8'd0;
            x_q     <= 8'sd0;
            acc_q   <= '0;
            i_q     <= 8'd0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            y_q     <= 8'sd0;
        end else begin
            state_q <= state_d;
            abus_q  <= abus_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            y_q     <= y_d;
        end
    end

    assign abus_r = abus_q;
    assign busy   = busy_q;
    assign ack    = ack_q;
    assign y      = y_q;
    assign acc    = acc_q;

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequencer/MAC stage sitting directly downstream of the layer's 256×8 weight/input memory: it drives the memory read address bus, consumes the read data, and computes one neuron output y = act(sat8((BIAS + Σ x[i]·w[i]) >>> SHIFT)). Inputs x[i] are stored at X_BASE+i and weights w[i] at W_BASE+i. A start request launches one dot product; a one-cycle ack marks the result.

## Interface
- N_IN, 4: number of inputs per neuron, 1..255
- X_BASE, 0: memory address of x[0]
- W_BASE, 128: memory address of w[0]
- ACC_W, 20: accumulator width in bits, signed, ≥17
- BIAS, 0: signed ACC_W-bit initial accumulator value
- SHIFT, 0: arithmetic right shift applied before saturation, 0..ACC_W-1
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  1  start request, sampled in IDLE
- abus_r  out  8  memory read address, registered
- dbus_r  in  8  memory read data, signed two's complement
- busy  out  1  high while a computation is in progress
- ack  out  1  one-cycle pulse: y valid
- y  out  8  signed neuron output, held until next ack
- acc  out  ACC_W  raw accumulator, debug/observation

## Operation
- Reset values: abus_r=0, busy=0, ack=0, y=0, acc=0, index i=0, state IDLE.
- States: IDLE, RDX, RDW, ACT.
- IDLE: if req=1 → abus_r=X_BASE, acc=BIAS, i=0, busy=1, → RDX. req=0 → stay.
- RDX: x_reg←dbus_r; abus_r←W_BASE+i; → RDW.
- RDW: acc←acc + sext(x_reg·dbus_r) (8×8 signed → 16-bit signed product, sign-extended to ACC_W); if i=N_IN-1 → ACT, else i←i+1, abus_r←X_BASE+i+1, → RDX.
- ACT: t = acc >>> SHIFT; s = clamp(t, -128, 127); y←s; ack←1; busy←0; → IDLE.
- Address arithmetic is mod 256 (wrap 255→0).
- Accumulator wraps modulo 2^ACC_W on overflow; no saturation inside the sum.
- req while busy=1 is ignored; req held high at the ack cycle starts a new computation on the following edge (back-to-back allowed).
- rst asserted mid-operation aborts immediately to reset values; no ack is produced.

## Timing
- Memory returns data for abus_r by the next rising edge (memory samples on falling edge); block captures dbus_r one cycle after driving abus_r.
- Each input costs 2 cycles. With req sampled at edge 0: element i accumulated at edge 2i+2; ACT at edge 2N_IN+1 updates y and raises ack; ack drops at edge 2N_IN+2.
- Latency req→ack = 2·N_IN+1 cycles (9 for N_IN=4).
- busy high from edge 0 through edge 2N_IN+1 (low in the ack cycle).
- y changes only on the edge that raises ack.

## Configuration
- NEURON_RELU_EN defined: activation is ReLU after saturation, y = max(s, 0).
- NEURON_RELU_EN undefined: linear activation, y = s (negative results pass through).

## Test plan
- N_IN=4, x=[1,2,3,4], w=[1,1,1,1], BIAS=0, SHIFT=0, req pulse → ack exactly 9 cycles later, acc=10, y=10, busy low in ack cycle.
- x=[-3,-3,-3,-3], w=[5,1,1,1] → acc=-24; with NEURON_RELU_EN y=0, without y=-24 (0xE8).
- x=[127]×4, w=[127]×4 → acc=64516, y=127 (saturated); x=[-128]×4, w=[127]×4, no ReLU → y=-128.
- X_BASE=254, N_IN=4 → abus_r sequence 254,W,255,W+1,0,W+2,1,W+3; SHIFT=2 with acc=10 → y=2.
- req held high continuously → ack pulses every 10 cycles; req toggled while busy → no extra start, single ack.
- rst asserted at edge 4 of a computation → all outputs 0 asynchronously, no ack; fresh req afterwards yields correct result.
